// File: rtl/overlay_pkg.sv
// Shared types for the overlay fetch path: ABGR4444 pixel layout and fetch FSM states.
package overlay_pkg;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] r;
  } ovl_pix_t;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} ovl_state_t;

  // Selects pixel n (half 0) or pixel n+1 (half 1) from a 32-bit SDRAM word.
  function automatic ovl_pix_t word_half(input logic [31:0] word, input logic half);
    return half ? ovl_pix_t'(word[31:16]) : ovl_pix_t'(word[15:0]);
  endfunction

endpackage

// File: rtl/overlay_fifo.sv
// Prefetch FIFO of 32-bit overlay words; free slots count the in-flight read as already used.
module overlay_fifo
  import overlay_pkg::*;
#(
  parameter int unsigned FIFO_WORDS = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        push,
  input  logic [31:0]                 wdata,
  input  logic                        pop,
  input  logic                        reserve,
  output logic [31:0]                 head,
  output logic                        empty,
  output logic [$clog2(FIFO_WORDS):0] free
);

  localparam int unsigned PW = $clog2(FIFO_WORDS);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   mem [FIFO_WORDS];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_pop;

  assign do_pop = pop && !empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign free  = CW'(FIFO_WORDS) - count - {{PW{1'b0}}, reserve};

endmodule

// File: rtl/overlay_fetch.sv
// Streams ABGR4444 overlay pixels from SDRAM through a prefetch FIFO, one pixel per active ce_pix.
module overlay_fetch
  import overlay_pkg::*;
#(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned FIFO_WORDS = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic              enable,
  input  logic              vsync,
  input  logic              de,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_valid,
  input  logic [31:0]       mem_rdata,
  output logic [3:0]        bg_r,
  output logic [3:0]        bg_g,
  output logic [3:0]        bg_b,
  output logic [3:0]        bg_a,
  output logic              underrun
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  ovl_state_t                 state_q, state_d;
  logic                       vsync_q;
  logic                       rise;
  logic                       outstanding_q;
  logic                       discard_q;
  logic                       half_q;
  logic [ADDR_W-1:0]          addr_q;
  ovl_pix_t                   pix_q;
  logic                       underrun_q;

  logic                       flush;
  logic                       req;
  logic                       strobe;
  logic                       take;
  logic                       advance;
  logic [31:0]                head;
  logic                       empty;
  logic [$clog2(FIFO_WORDS):0] free;

  assign rise = ce_pix && vsync && !vsync_q;

  overlay_fifo #(.FIFO_WORDS(FIFO_WORDS)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (take),
    .wdata   (mem_rdata),
    .pop     (advance && half_q),
    .reserve (outstanding_q),
    .head    (head),
    .empty   (empty),
    .free    (free)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // enable-low and a vsync rise both flush; every other action is suppressed in that cycle.
  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    req     = 1'b0;
    strobe  = 1'b0;
    take    = 1'b0;
    advance = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      flush   = 1'b1;
    end else if (rise) begin
      state_d = PRIME;
      flush   = 1'b1;
    end else begin
      strobe  = ce_pix && de && (state_q != IDLE);
      req     = (state_q != IDLE) && !outstanding_q && (free != '0);
      take    = mem_valid && outstanding_q && !discard_q;
      advance = strobe && (state_q == RUN) && !empty;
      if (state_q == PRIME && free == '0) state_d = RUN;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q       <= 1'b0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      half_q        <= 1'b0;
      addr_q        <= BASE;
      pix_q         <= '0;
      underrun_q    <= 1'b0;
    end else begin
      if (ce_pix) vsync_q <= vsync;

      if (req)            outstanding_q <= 1'b1;
      else if (mem_valid) outstanding_q <= 1'b0;

      // A read still in flight at flush time must not land in the new frame.
      if (mem_valid)                   discard_q <= 1'b0;
      else if (flush && outstanding_q) discard_q <= 1'b1;

      if (flush)    addr_q <= BASE;
      else if (req) addr_q <= addr_q + ADDR_W'(2);

      if (flush)        half_q <= 1'b0;
      else if (advance) half_q <= ~half_q;

      if (!enable)      pix_q <= '0;
      else if (advance) pix_q <= word_half(head, half_q);
      else if (strobe)  pix_q <= '0;

      if (flush)                   underrun_q <= 1'b0;
      else if (strobe && !advance) underrun_q <= 1'b1;
    end
  end

  assign mem_addr = addr_q;
  assign mem_req  = req;
  assign bg_a     = pix_q.a;
  assign bg_b     = pix_q.b;
  assign bg_g     = pix_q.g;
  assign bg_r     = pix_q.r;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_overlay_fetch.sv
// Randomized bench for overlay_fetch: SDRAM responder plus a frame-level pixel/address reference model.
module tb_overlay_fetch;

  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned FIFO_WORDS = 4;
  localparam int unsigned BASE       = 32'h00FF_FFF8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic              clock = 1'b0;
  logic              reset_n, ce_pix, enable, vsync, de, mem_req, mem_valid, underrun;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic [3:0]        bg_r, bg_g, bg_b, bg_a;

  always #5 clock = ~clock;

  overlay_fetch #(.ADDR_W(ADDR_W), .FIFO_WORDS(FIFO_WORDS), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset_n(reset_n), .ce_pix(ce_pix), .enable(enable), .vsync(vsync), .de(de),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .bg_a(bg_a), .underrun(underrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Overlay picture content: pixel value as a hash of its word address.
  function automatic logic [15:0] pix_at(input logic [ADDR_W-1:0] a);
    logic [31:0] x;
    x = 32'(a) * 32'd2654435761;
    return x[31:16];
  endfunction

  // memory responder state
  logic              tb_out, pend, force_vs_on_valid, dense;
  int                pend_cnt, lat_lo, lat_hi, reqs_frame;
  logic [ADDR_W-1:0] pend_addr, exp_addr;
  // frame model state
  logic              vs_seen, m_active, m_under, m_unknown;
  logic [15:0]       m_pix;
  int unsigned       m_k;
  logic              p_strobe, p_act, p_en, p_rise;

  task automatic model_init();
    tb_out = 0; pend = 0; pend_cnt = 0; force_vs_on_valid = 0; reqs_frame = 0;
    pend_addr = '0; exp_addr = ADDR_W'(BASE);
    vs_seen = 0; m_active = 0; m_under = 0; m_unknown = 0; m_pix = '0; m_k = 0;
    p_strobe = 0; p_act = 0; p_en = 0; p_rise = 0;
  endtask

  task automatic observe();
    logic [15:0] got;
    logic [15:0] want;
    got = {bg_a, bg_b, bg_g, bg_r};
    if (!p_en) begin
      check("off_pix", 32'(got), 32'h0);
      check("off_under", 32'(underrun), 32'h0);
      m_pix = '0; m_under = 0; m_unknown = 0;
    end else if (p_rise) begin
      if (!m_unknown) check("vs_hold", 32'(got), 32'(m_pix));
      check("vs_under_clr", 32'(underrun), 32'h0);
      m_under = 0; m_k = 0;
    end else if (p_strobe && p_act) begin
      if (m_under) begin
        check("under_sticky", 32'(underrun), 32'h1);
        m_unknown = 1;
      end else if (underrun) begin
        check("under_pix", 32'(got), 32'h0);
        m_under = 1; m_pix = '0; m_unknown = 0;
      end else begin
        want = pix_at(ADDR_W'(BASE + m_k));
        check("pix", 32'(got), 32'(want));
        m_pix = want; m_k++; m_unknown = 0;
      end
    end else begin
      if (!m_unknown) check("hold_pix", 32'(got), 32'(m_pix));
      check("under_hold", 32'(underrun), 32'(m_under));
    end
  endtask

  task automatic tick(input logic ce, input logic d, input logic vs, input logic en);
    logic rise, strobe, v, allowed;
    @(posedge clock); #1;
    observe();
    v = 0;
    if (pend) begin
      if (pend_cnt == 0) begin v = 1; pend = 0; end
      else pend_cnt--;
    end
    if (force_vs_on_valid && v && !vs_seen && en) begin
      ce = 1; vs = 1; force_vs_on_valid = 0;
    end
    ce_pix = ce; de = d; vsync = vs; enable = en;
    mem_valid = v;
    mem_rdata = v ? {pix_at(ADDR_W'(pend_addr + 1'b1)), pix_at(pend_addr)} : 32'h0;
    rise = ce && vs && !vs_seen;
    if (ce) vs_seen = vs;
    strobe = ce && d && en && !rise;
    #1;
    allowed = m_active && en && !rise && !tb_out;
    if (mem_req) reqs_frame++;
    if (!allowed) check("req_gate", 32'(mem_req), 32'h0);
    else if (mem_req) begin
      check("req_addr", 32'(mem_addr), 32'(exp_addr));
      exp_addr = ADDR_W'(exp_addr + 2'd2);
    end
    if (v) tb_out = 0;
    if (mem_req) begin
      tb_out = 1; pend = 1; pend_addr = mem_addr;
      pend_cnt = int'($urandom_range(lat_hi, lat_lo)) - 1;
    end
    p_strobe = strobe; p_act = m_active; p_en = en; p_rise = rise;
    if (!en) m_active = 0;
    else if (rise) begin
      m_active = 1; exp_addr = ADDR_W'(BASE); reqs_frame = 0;
    end
  endtask

  function automatic logic rc();
    return dense ? 1'b1 : 1'($urandom_range(1, 0));
  endfunction

  task automatic vs_pulse();
    tick(H, L, L, H); tick(H, L, H, H); tick(H, L, H, H);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) tick(rc(), L, L, H);
  endtask

  task automatic line(input int w, input int gap);
    for (int i = 0; i < w; i++) tick(rc(), H, L, H);
    blank(gap);
  endtask

  task automatic async_reset();
    #2;
    reset_n = 0;
    #1;
    check("rst_pix", 32'({bg_a, bg_b, bg_g, bg_r}), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_under", 32'(underrun), 32'h0);
    ce_pix = 0; de = 0; vsync = 0; mem_valid = 0; mem_rdata = '0;
    model_init();
    @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    int guard;
    model_init();
    reset_n = 0; ce_pix = 0; enable = 0; vsync = 0; de = 0; mem_valid = 0; mem_rdata = '0;
    lat_lo = 3; lat_hi = 3; dense = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    repeat (4) tick(H, L, L, L);

    // primed FIFO covers 8 back-to-back pixels
    vs_pulse(); blank(30); line(8, 4);
    check("t1_no_under", 32'(underrun), 32'h0);
    check("t1_count", 32'(m_k), 32'd8);

    // long de-low stretch: fetch stops at FIFO capacity
    vs_pulse(); blank(100);
    check("t4_reqs", 32'(reqs_frame), 32'(FIFO_WORDS));
    line(12, 4);

    // slow memory with de straight after vsync
    lat_lo = 40; lat_hi = 40;
    vs_pulse(); line(30, 2);
    check("t2_under", 32'(underrun), 32'h1);
    lat_lo = 1; lat_hi = 4;
    vs_pulse(); blank(60); line(10, 4);

    // vsync rise lands on the mem_valid cycle
    lat_lo = 5; lat_hi = 5;
    vs_pulse(); blank(30); line(6, 0);
    force_vs_on_valid = 1;
    guard = 0;
    while (force_vs_on_valid && guard < 50) begin tick(H, H, L, H); guard++; end
    check("t3_sync", 32'(force_vs_on_valid), 32'h0);
    blank(30); line(10, 4);

    // enable drop with a read in flight, quick re-enable before it returns
    lat_lo = 12; lat_hi = 12;
    vs_pulse(); blank(60); line(6, 0);
    guard = 0;
    while (!tb_out && guard < 30) begin tick(H, H, L, H); guard++; end
    check("t5_inflight", 32'(tb_out), 32'h1);
    tick(H, L, L, L); tick(H, L, L, L); tick(H, L, L, L);
    lat_lo = 2; lat_hi = 3;
    blank(3);
    vs_pulse(); blank(40); line(8, 4);

    // randomized frames
    dense = 0; lat_lo = 1; lat_hi = 4;
    for (int f = 0; f < 8; f++) begin
      vs_pulse();
      blank(int'($urandom_range(40, 20)));
      for (int ln = 0; ln < int'($urandom_range(5, 3)); ln++)
        line(int'($urandom_range(12, 4)), int'($urandom_range(10, 4)));
    end

    // asynchronous reset mid-line
    dense = 1;
    vs_pulse(); blank(30); line(5, 0);
    async_reset();
    repeat (3) tick(H, L, L, H);
    vs_pulse(); blank(30); line(8, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
